// File: rtl/spart.sv
// -----------------------------------------------------------------------------
// spart -- Special Purpose Asynchronous Receiver/Transmitter
//
// A byte-wide UART with a programmable 16-bit baud divisor, 16x oversampling
// and a fixed 8N1 frame, LSB first. The transmitter and receiver are
// independent, so the block runs full duplex.
//
// Ports
//   clk      : system clock; all state changes on the rising edge
//   rst      : asynchronous, active-low reset
//   iocs     : chip select; the bus is accessed only while this is 1
//   iorw     : 1 = read (spart drives databus), 0 = write (host drives it)
//   ioaddr   : 00 TX/RX buffer, 01 status, 10 divisor low, 11 divisor high
//   databus  : bidirectional data bus; high-Z unless a read is selected
//   rda      : receive data available
//   tbr      : transmit buffer ready (transmitter idle)
//   txd      : serial transmit line, idle high
//   rxd      : serial receive line, asynchronous, idle high
//
// Parameter
//   DIV_RESET : divisor value loaded into the divisor buffer and the baud
//               counter on reset. The baud tick period is divisor+1 clocks.
// -----------------------------------------------------------------------------
module spart #(
    parameter logic [15:0] DIV_RESET = 16'h0145
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic       rda,
    output logic       tbr,
    output logic       txd,
    input  logic       rxd
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // Bus decode
    logic        rd_en_s;
    logic        wr_en_s;
    logic        tx_wr_s;
    logic        rx_rd_s;
    logic [7:0]  rd_data_s;

    // Baud generator
    logic [15:0] db_r;
    logic        reload_r;
    logic [15:0] baud_cnt_r;
    logic        tick_s;

    // Transmitter
    state_t      tx_state_r, tx_state_nxt_s;
    logic [7:0]  tx_shift_r, tx_shift_nxt_s;
    logic [3:0]  tx_tcnt_r, tx_tcnt_nxt_s;
    logic [2:0]  tx_bcnt_r, tx_bcnt_nxt_s;
    logic        txd_r, txd_nxt_s;
    logic        tbr_r, tbr_nxt_s;

    // Receiver
    logic        rx_meta_r;
    logic        rx_sync_r;
    logic        rx_prev_r;
    logic        rx_fall_s;
    state_t      rx_state_r, rx_state_nxt_s;
    logic [3:0]  rx_tcnt_r, rx_tcnt_nxt_s;
    logic [2:0]  rx_bcnt_r, rx_bcnt_nxt_s;
    logic [7:0]  rx_shift_r, rx_shift_nxt_s;
    logic [7:0]  rx_data_r, rx_data_nxt_s;
    logic        rda_r, rda_nxt_s;

    assign rd_en_s = iocs & iorw;
    assign wr_en_s = iocs & ~iorw;
    // A TX buffer write while a byte is in flight is dropped so it cannot
    // corrupt the shifter.
    assign tx_wr_s = wr_en_s & (ioaddr == 2'b00) & tbr_r;
    assign rx_rd_s = rd_en_s & (ioaddr == 2'b00);

    assign rda = rda_r;
    assign tbr = tbr_r;
    assign txd = txd_r;

    // Read data mux; reads are combinational so the host sees data in-cycle
    always_comb begin
        rd_data_s = 8'h00;
        case (ioaddr)
            2'b00:   rd_data_s = rx_data_r;
            2'b01:   rd_data_s = {6'b000000, rda_r, tbr_r};
            2'b10:   rd_data_s = db_r[7:0];
            2'b11:   rd_data_s = db_r[15:8];
            default: rd_data_s = 8'h00;
        endcase
    end

    assign databus = rd_en_s ? rd_data_s : 8'hzz;

    // Divisor buffer writes; any write requests a counter reload next cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_r     <= DIV_RESET;
            reload_r <= 1'b0;
        end else begin
            reload_r <= 1'b0;
            if (wr_en_s && (ioaddr == 2'b10)) begin
                db_r[7:0] <= databus;
                reload_r  <= 1'b1;
            end else if (wr_en_s && (ioaddr == 2'b11)) begin
                db_r[15:8] <= databus;
                reload_r   <= 1'b1;
            end
        end
    end

    // Baud down-counter: ticks at zero and reloads, giving a DB+1 clock period
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            baud_cnt_r <= DIV_RESET;
        end else if (reload_r || (baud_cnt_r == 16'd0)) begin
            baud_cnt_r <= db_r;
        end else begin
            baud_cnt_r <= baud_cnt_r - 16'd1;
        end
    end

    // The reload cycle restarts the tick phase, so no tick is issued then.
    assign tick_s = (baud_cnt_r == 16'd0) & ~reload_r;

    // Transmitter state and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_r <= ST_IDLE;
            tx_shift_r <= 8'h00;
            tx_tcnt_r  <= 4'd0;
            tx_bcnt_r  <= 3'd0;
            txd_r      <= 1'b1;
            tbr_r      <= 1'b1;
        end else begin
            tx_state_r <= tx_state_nxt_s;
            tx_shift_r <= tx_shift_nxt_s;
            tx_tcnt_r  <= tx_tcnt_nxt_s;
            tx_bcnt_r  <= tx_bcnt_nxt_s;
            txd_r      <= txd_nxt_s;
            tbr_r      <= tbr_nxt_s;
        end
    end

    // Transmitter next state: each bit lasts 16 ticks; txd is registered so
    // the line value is updated on the tick that ends the previous bit.
    always_comb begin
        tx_state_nxt_s = tx_state_r;
        tx_shift_nxt_s = tx_shift_r;
        tx_tcnt_nxt_s  = tx_tcnt_r;
        tx_bcnt_nxt_s  = tx_bcnt_r;
        txd_nxt_s      = txd_r;
        tbr_nxt_s      = tbr_r;
        case (tx_state_r)
            ST_IDLE: begin
                if (tx_wr_s) begin
                    tx_shift_nxt_s = databus;
                    tx_tcnt_nxt_s  = 4'd0;
                    txd_nxt_s      = 1'b0;
                    tbr_nxt_s      = 1'b0;
                    tx_state_nxt_s = ST_START;
                end else begin
                    txd_nxt_s = 1'b1;
                    tbr_nxt_s = 1'b1;
                end
            end
            ST_START: begin
                if (tick_s) begin
                    tx_tcnt_nxt_s = tx_tcnt_r + 4'd1;
                    if (tx_tcnt_r == 4'd15) begin
                        tx_bcnt_nxt_s  = 3'd0;
                        txd_nxt_s      = tx_shift_r[0];
                        tx_state_nxt_s = ST_DATA;
                    end else begin
                        tx_state_nxt_s = ST_START;
                    end
                end else begin
                    tx_tcnt_nxt_s = tx_tcnt_r;
                end
            end
            ST_DATA: begin
                if (tick_s) begin
                    tx_tcnt_nxt_s = tx_tcnt_r + 4'd1;
                    if ((tx_tcnt_r == 4'd15) && (tx_bcnt_r == 3'd7)) begin
                        txd_nxt_s      = 1'b1;
                        tx_state_nxt_s = ST_STOP;
                    end else if (tx_tcnt_r == 4'd15) begin
                        tx_shift_nxt_s = {1'b0, tx_shift_r[7:1]};
                        txd_nxt_s      = tx_shift_r[1];
                        tx_bcnt_nxt_s  = tx_bcnt_r + 3'd1;
                    end else begin
                        tx_state_nxt_s = ST_DATA;
                    end
                end else begin
                    tx_tcnt_nxt_s = tx_tcnt_r;
                end
            end
            ST_STOP: begin
                if (tick_s) begin
                    tx_tcnt_nxt_s = tx_tcnt_r + 4'd1;
                    if (tx_tcnt_r == 4'd15) begin
                        tbr_nxt_s      = 1'b1;
                        tx_state_nxt_s = ST_IDLE;
                    end else begin
                        tx_state_nxt_s = ST_STOP;
                    end
                end else begin
                    tx_tcnt_nxt_s = tx_tcnt_r;
                end
            end
            default: begin
                txd_nxt_s      = 1'b1;
                tbr_nxt_s      = 1'b1;
                tx_state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Two-flop synchronizer plus one history flop for falling-edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= rxd;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    assign rx_fall_s = rx_prev_r & ~rx_sync_r;

    // Receiver state and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state_r <= ST_IDLE;
            rx_tcnt_r  <= 4'd0;
            rx_bcnt_r  <= 3'd0;
            rx_shift_r <= 8'h00;
            rx_data_r  <= 8'h00;
            rda_r      <= 1'b0;
        end else begin
            rx_state_r <= rx_state_nxt_s;
            rx_tcnt_r  <= rx_tcnt_nxt_s;
            rx_bcnt_r  <= rx_bcnt_nxt_s;
            rx_shift_r <= rx_shift_nxt_s;
            rx_data_r  <= rx_data_nxt_s;
            rda_r      <= rda_nxt_s;
        end
    end

    // Receiver next state: the start bit is checked at its midpoint (tick 8),
    // after which every 16th tick lands mid-bit. A completing byte wins over
    // a simultaneous buffer read, and overwrites an unread byte.
    always_comb begin
        rx_state_nxt_s = rx_state_r;
        rx_tcnt_nxt_s  = rx_tcnt_r;
        rx_bcnt_nxt_s  = rx_bcnt_r;
        rx_shift_nxt_s = rx_shift_r;
        rx_data_nxt_s  = rx_data_r;
        if (rx_rd_s) begin
            rda_nxt_s = 1'b0;
        end else begin
            rda_nxt_s = rda_r;
        end
        case (rx_state_r)
            ST_IDLE: begin
                if (rx_fall_s) begin
                    rx_tcnt_nxt_s  = 4'd0;
                    rx_state_nxt_s = ST_START;
                end else begin
                    rx_state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s && (rx_tcnt_r == 4'd7)) begin
                    rx_tcnt_nxt_s = 4'd0;
                    rx_bcnt_nxt_s = 3'd0;
                    if (rx_sync_r) begin
                        rx_state_nxt_s = ST_IDLE;
                    end else begin
                        rx_state_nxt_s = ST_DATA;
                    end
                end else if (tick_s) begin
                    rx_tcnt_nxt_s = rx_tcnt_r + 4'd1;
                end else begin
                    rx_tcnt_nxt_s = rx_tcnt_r;
                end
            end
            ST_DATA: begin
                if (tick_s) begin
                    rx_tcnt_nxt_s = rx_tcnt_r + 4'd1;
                    if (rx_tcnt_r == 4'd15) begin
                        rx_shift_nxt_s = {rx_sync_r, rx_shift_r[7:1]};
                        rx_bcnt_nxt_s  = rx_bcnt_r + 3'd1;
                        if (rx_bcnt_r == 3'd7) begin
                            rx_state_nxt_s = ST_STOP;
                        end else begin
                            rx_state_nxt_s = ST_DATA;
                        end
                    end else begin
                        rx_state_nxt_s = ST_DATA;
                    end
                end else begin
                    rx_tcnt_nxt_s = rx_tcnt_r;
                end
            end
            ST_STOP: begin
                if (tick_s) begin
                    rx_tcnt_nxt_s = rx_tcnt_r + 4'd1;
                    if (rx_tcnt_r == 4'd15) begin
                        rx_state_nxt_s = ST_IDLE;
                        if (rx_sync_r) begin
                            rx_data_nxt_s = rx_shift_r;
                            rda_nxt_s     = 1'b1;
                        end else begin
                            rx_data_nxt_s = rx_data_r;
                        end
                    end else begin
                        rx_state_nxt_s = ST_STOP;
                    end
                end else begin
                    rx_tcnt_nxt_s = rx_tcnt_r;
                end
            end
            default: begin
                rx_state_nxt_s = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spart.sv
// -----------------------------------------------------------------------------
// tb_spart -- self-checking bench for spart.
// A transaction-level model predicts txd/tbr from tick counts (baud ticks
// computed arithmetically from the divisor and its load cycle), rda/RX data
// from the frames the bench drives, and every bus read value. A compare
// process checks the DUT against the model on every falling clock edge.
// -----------------------------------------------------------------------------
module tb_spart;

    logic       clk;
    logic       rst;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    wire  [7:0] databus;
    logic       rda;
    logic       tbr;
    logic       txd;
    logic       rxd;
    logic       drv_en;
    logic [7:0] drv_d;

    assign databus = drv_en ? drv_d : 8'hzz;

    spart #(.DIV_RESET(16'h0145)) dut (
        .clk(clk), .rst(rst), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
        .databus(databus), .rda(rda), .tbr(tbr), .txd(txd), .rxd(rxd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          cyc = 0;
    logic [15:0] m_db;
    logic [15:0] m_div;
    int          m_l;
    bit          m_reload;
    bit          m_tx_act;
    int          m_tx_cnt;
    logic [7:0]  m_tx_byte;
    logic        m_txd;
    logic        m_tbr;
    logic        m_rda;
    logic [7:0]  m_rxdata;
    bit          rx_pend;
    int          rx_w0;
    int          rx_w1;
    logic [7:0]  rx_byte;
    logic        rx_ok;

    // Frame bit k of an 8N1 frame: start 0, data LSB first, stop 1.
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        else if (k >= 9) return 1'b1;
        else return b[k-1];
    endfunction

    task automatic model_reset();
        m_db = 16'h0145; m_div = 16'h0145; m_l = cyc; m_reload = 1'b0;
        m_tx_act = 1'b0; m_tx_cnt = 0; m_tx_byte = 8'h00;
        m_txd = 1'b1; m_tbr = 1'b1; m_rda = 1'b0; m_rxdata = 8'h00;
        rx_pend = 1'b0;
    endtask

    task automatic model_step();
        bit   tick;
        logic tbr_pre;
        if (m_reload) begin
            tick = 1'b0; m_div = m_db; m_l = cyc; m_reload = 1'b0;
        end else begin
            tick = ((cyc - m_l) % (int'(m_div) + 1)) == 0;
        end
        tbr_pre = m_tbr;
        if (m_tx_act && tick) begin
            m_tx_cnt++;
            if (m_tx_cnt == 160) begin m_tx_act = 1'b0; m_tbr = 1'b1; end
        end
        if (iocs && !iorw) begin
            case (ioaddr)
                2'b00: if (tbr_pre) begin
                    m_tx_act = 1'b1; m_tx_cnt = 0; m_tx_byte = drv_d; m_tbr = 1'b0;
                end
                2'b10: begin m_db[7:0] = drv_d; m_reload = 1'b1; end
                2'b11: begin m_db[15:8] = drv_d; m_reload = 1'b1; end
                default: ;
            endcase
        end
        m_txd = m_tx_act ? frame_bit(m_tx_byte, m_tx_cnt / 16) : 1'b1;
        if (iocs && iorw && ioaddr == 2'b00) m_rda = 1'b0;
        if (rx_pend && cyc == rx_w1) begin
            if (rx_ok) begin m_rda = 1'b1; m_rxdata = rx_byte; end
            rx_pend = 1'b0;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else begin cyc++; model_step(); end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        logic [7:0] exp_bus;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("txd", {15'd0, txd}, {15'd0, m_txd});
                chk("tbr", {15'd0, tbr}, {15'd0, m_tbr});
                if (!(rx_pend && cyc >= rx_w0)) begin
                    chk("rda", {15'd0, rda}, {15'd0, m_rda});
                    if (iocs && iorw) begin
                        case (ioaddr)
                            2'b00:   exp_bus = m_rxdata;
                            2'b01:   exp_bus = {6'd0, m_rda, m_tbr};
                            2'b10:   exp_bus = m_db[7:0];
                            default: exp_bus = m_db[15:8];
                        endcase
                        chk("read_bus", {8'd0, databus}, {8'd0, exp_bus});
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        iocs = 1'b1; iorw = 1'b0; ioaddr = a; drv_d = d; drv_en = 1'b1;
        @(posedge clk); #1;
        iocs = 1'b0; iorw = 1'b1; drv_en = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        @(posedge clk); #1;
        iocs = 1'b1; iorw = 1'b1; ioaddr = a;
        #2 d = databus;
        @(posedge clk); #1;
        iocs = 1'b0;
    endtask

    // Drives one frame at 64 clocks per bit; the byte must appear in the
    // middle of the stop bit, allowing for synchronizer and tick phase.
    task automatic rx_frame(input logic [7:0] b, input logic stop_ok);
        @(posedge clk); #1;
        rx_byte = b; rx_ok = stop_ok; rx_w0 = cyc + 600; rx_w1 = cyc + 620; rx_pend = 1'b1;
        for (int k = 0; k < 10; k++) begin
            rxd = (k == 9) ? stop_ok : frame_bit(b, k);
            repeat (64) @(posedge clk);
            #1;
        end
        rxd = 1'b1;
    endtask

    task automatic wait_tbr(input int budget);
        int n;
        n = 0;
        while (tbr !== 1'b1 && n < budget) begin @(negedge clk); n++; end
        chk("tbr_wait", {15'd0, tbr}, 16'd1);
    endtask

    // ---------------- test sequence ----------------
    logic [7:0] rd;
    logic [7:0] last_good;
    logic [9:0] a5_seq;
    logic       h_txd [700];
    logic       h_mtx [700];
    logic       h_tbr [700];
    int         r_idx;
    int         run_len;
    int         dv;
    logic [7:0] tb_byte;
    logic [7:0] rb_byte;
    logic       rb_ok;

    initial begin
        rst = 1'b0; iocs = 1'b0; iorw = 1'b1; ioaddr = 2'b00;
        drv_en = 1'b0; drv_d = 8'h00; rxd = 1'b1;
        a5_seq = 10'b1101001010;
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Reset state and divisor reset value
        chk("rst_txd", {15'd0, txd}, 16'd1);
        chk("rst_tbr", {15'd0, tbr}, 16'd1);
        chk("rst_rda", {15'd0, rda}, 16'd0);
        bus_read(2'b01, rd); chk("rst_status", {8'd0, rd}, 16'h0001);
        bus_read(2'b10, rd); chk("rst_db_lo", {8'd0, rd}, 16'h0045);
        bus_read(2'b11, rd); chk("rst_db_hi", {8'd0, rd}, 16'h0001);
        bus_read(2'b00, rd); chk("rst_rxdata", {8'd0, rd}, 16'h0000);
        bus_write(2'b01, 8'hFF);
        bus_read(2'b01, rd); chk("status_wr_ignored", {8'd0, rd}, 16'h0001);

        // Divisor programming
        bus_write(2'b10, 8'h03);
        bus_write(2'b11, 8'h00);
        bus_read(2'b10, rd); chk("db_lo", {8'd0, rd}, 16'h0003);
        bus_read(2'b11, rd); chk("db_hi", {8'd0, rd}, 16'h0000);

        // Transmit 8'hA5 and record the line
        bus_write(2'b00, 8'hA5);
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            h_txd[i] = txd; h_mtx[i] = m_txd; h_tbr[i] = tbr;
        end
        chk("tbr_after_wr", {15'd0, h_tbr[0]}, 16'd0);
        for (int k = 0; k < 10; k++) begin
            chk("a5_txd_bit", {15'd0, h_txd[64*k+32]}, {15'd0, a5_seq[k]});
            chk("a5_model_bit", {15'd0, h_mtx[64*k+32]}, {15'd0, a5_seq[k]});
        end
        r_idx = -1; run_len = 0;
        for (int i = 1; i < 700; i++)
            if (r_idx < 0 && h_txd[i-1] == 1'b0 && h_txd[i] == 1'b1) r_idx = i;
        if (r_idx >= 0)
            for (int i = r_idx; i < 700 && h_txd[i] == 1'b1; i++) run_len++;
        chk("bit_period", run_len[15:0], 16'd64);
        chk("tbr_after_stop", {15'd0, h_tbr[699]}, 16'd1);

        // Receive 8'h3C
        rx_frame(8'h3C, 1'b1);
        chk("rx_rda_set", {15'd0, rda}, 16'd1);
        bus_read(2'b00, rd); chk("rx_data_3c", {8'd0, rd}, 16'h003C);
        @(negedge clk); chk("rx_rda_clr", {15'd0, rda}, 16'd0);
        last_good = 8'h3C;

        // Glitch, then bad stop bit
        @(posedge clk); #1; rxd = 1'b0;
        repeat (20) @(posedge clk); #1; rxd = 1'b1;
        repeat (100) @(negedge clk);
        chk("glitch_no_rda", {15'd0, rda}, 16'd0);
        rx_frame(8'h55, 1'b0);
        repeat (10) @(negedge clk);
        chk("badstop_no_rda", {15'd0, rda}, 16'd0);
        bus_read(2'b00, rd); chk("badstop_data", {8'd0, rd}, 16'h003C);

        // Overrun
        rx_frame(8'h11, 1'b1);
        rx_frame(8'h22, 1'b1);
        chk("ovr_rda", {15'd0, rda}, 16'd1);
        bus_read(2'b00, rd); chk("ovr_data", {8'd0, rd}, 16'h0022);
        last_good = 8'h22;

        // Busy write is dropped (model checks the frame stays 8'h0F)
        bus_write(2'b00, 8'h0F);
        repeat (100) @(negedge clk);
        bus_write(2'b00, 8'hF0);
        chk("busy_tbr", {15'd0, tbr}, 16'd0);
        wait_tbr(800);

        // Random TX with random divisors
        for (int it = 0; it < 4; it++) begin
            dv = $urandom_range(0, 5);
            tb_byte = 8'($urandom);
            bus_write(2'b10, 8'(dv));
            bus_write(2'b11, 8'h00);
            bus_write(2'b00, tb_byte);
            wait_tbr(170 * (dv + 1) + 50);
        end

        // Random full-duplex traffic at divisor 3
        bus_write(2'b10, 8'h03);
        bus_write(2'b11, 8'h00);
        for (int it = 0; it < 4; it++) begin
            tb_byte = 8'($urandom);
            rb_byte = 8'($urandom);
            rb_ok   = ($urandom_range(0, 3) != 0);
            fork
                begin bus_write(2'b00, tb_byte); wait_tbr(800); end
                rx_frame(rb_byte, rb_ok);
            join
            if (rb_ok) last_good = rb_byte;
            chk("fd_rda", {15'd0, rda}, {15'd0, rb_ok});
            bus_read(2'b00, rd); chk("fd_data", {8'd0, rd}, {8'd0, last_good});
        end

        // Reset in the middle of a transmit frame
        bus_write(2'b00, 8'hC3);
        repeat (200) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("mid_rst_txd", {15'd0, txd}, 16'd1);
        chk("mid_rst_tbr", {15'd0, tbr}, 16'd1);
        chk("mid_rst_rda", {15'd0, rda}, 16'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        bus_read(2'b01, rd); chk("mid_rst_status", {8'd0, rd}, 16'h0001);
        bus_read(2'b10, rd); chk("mid_rst_db_lo", {8'd0, rd}, 16'h0045);
        repeat (100) @(negedge clk);
        chk("mid_rst_txd_idle", {15'd0, txd}, 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
